// File: rtl/dstack_pkg.sv
// Shared types for the data-stack spill/fill controller: movement codes,
// controller FSM states and the movement-to-occupancy delta helper.
package dstack_pkg;

   typedef enum logic [1:0] {
      MOVE_NONE = 2'b00,
      MOVE_PUSH = 2'b01,
      MOVE_POP1 = 2'b10,
      MOVE_POP2 = 2'b11
   } move_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SPILL = 2'd1,
      FILL  = 2'd2
   } state_e;

   function automatic logic signed [2:0] movement_delta(input move_e m);
      case (m)
         MOVE_PUSH: return 3'sd1;
         MOVE_POP1: return -3'sd1;
         MOVE_POP2: return -3'sd2;
         default:   return 3'sd0;
      endcase
   endfunction

endpackage

// File: rtl/dstack_spill_control_if.sv
// Signal bundle between the spill controller (master) and its environment:
// core movement, stack bottom-end strobes and the memory request channel.
// Optional statistics outputs exist only when DSTACK_SPILL_STATS_EN is defined.
interface dstack_spill_control_if #(
   parameter int WORD_WIDTH = 32,
   parameter int DEPTH      = 32
);
   import dstack_pkg::*;

   localparam int OCC_W = $clog2(DEPTH) + 1;

   // Memory channel: mem_req rises with stable mem_we/mem_addr/mem_wdata and
   // holds until the one-cycle mem_ack; only one request is ever outstanding.
   logic [1:0]            movement;
   logic                  move_valid;
   logic                  stall;
   logic [WORD_WIDTH-1:0] bottom_value;
   logic                  bottom_pop;
   logic                  bottom_push;
   logic [WORD_WIDTH-1:0] bottom_push_value;
   logic [OCC_W-1:0]      occupancy;
   logic [WORD_WIDTH-1:0] spilled;
   logic                  underflow;
   logic                  mem_req;
   logic                  mem_we;
   logic [WORD_WIDTH-1:0] mem_addr;
   logic [WORD_WIDTH-1:0] mem_wdata;
   logic                  mem_ack;
   logic [WORD_WIDTH-1:0] mem_rdata;
   state_e                dbg_state;
`ifdef DSTACK_SPILL_STATS_EN
   logic [WORD_WIDTH-1:0] spill_count;
   logic [WORD_WIDTH-1:0] fill_count;
   logic [WORD_WIDTH-1:0] stall_cycles;

   modport master (
      input  movement, move_valid, bottom_value, mem_ack, mem_rdata,
      output stall, bottom_pop, bottom_push, bottom_push_value, occupancy,
             spilled, underflow, mem_req, mem_we, mem_addr, mem_wdata,
             dbg_state, spill_count, fill_count, stall_cycles
   );
   modport slave (
      output movement, move_valid, bottom_value, mem_ack, mem_rdata,
      input  stall, bottom_pop, bottom_push, bottom_push_value, occupancy,
             spilled, underflow, mem_req, mem_we, mem_addr, mem_wdata,
             dbg_state, spill_count, fill_count, stall_cycles
   );
`else
   modport master (
      input  movement, move_valid, bottom_value, mem_ack, mem_rdata,
      output stall, bottom_pop, bottom_push, bottom_push_value, occupancy,
             spilled, underflow, mem_req, mem_we, mem_addr, mem_wdata,
             dbg_state
   );
   modport slave (
      output movement, move_valid, bottom_value, mem_ack, mem_rdata,
      input  stall, bottom_pop, bottom_push, bottom_push_value, occupancy,
             spilled, underflow, mem_req, mem_we, mem_addr, mem_wdata,
             dbg_state
   );
`endif

endinterface

// File: rtl/dstack_spill_control.sv
// Keeps the on-chip data stack within DEPTH by spilling its bottom entry to
// memory above HIGH_WATER and filling it back below LOW_WATER.
// Define DSTACK_SPILL_STATS_EN to add spill/fill/stall statistics counters.
module dstack_spill_control
   import dstack_pkg::*;
#(
   parameter int WORD_WIDTH = 32,
   parameter int DEPTH      = 32,
   parameter int HIGH_WATER = 28,
   parameter int LOW_WATER  = 4,
   parameter int SPILL_BASE = 0
) (
   input logic                    clk,
   input logic                    reset_n,
   dstack_spill_control_if.master bus
);

   localparam int OCC_W = $clog2(DEPTH) + 1;

   state_e                r_state;
   logic [OCC_W-1:0]      r_occupancy;
   logic [WORD_WIDTH-1:0] r_spilled;
   logic [WORD_WIDTH-1:0] r_mem_addr;
   logic [WORD_WIDTH-1:0] r_mem_wdata;
   logic                  r_mem_req;
   logic                  r_mem_we;
   logic                  r_underflow;

   move_e            w_move;
   logic [1:0]       w_pop_n;
   logic             w_is_push;
   logic             w_is_pop;
   logic             w_short;
   logic             w_push_stall;
   logic             w_pop_stall;
   logic             w_stall;
   logic             w_commit;
   logic             w_spill_issue;
   logic             w_fill_issue;
   logic             w_fill_ack;
   int               w_sum;
   logic [OCC_W-1:0] w_occ_next;

   always_comb begin
      w_move        = move_e'(bus.movement);
      w_is_push     = (w_move == MOVE_PUSH);
      w_is_pop      = (w_move == MOVE_POP1) || (w_move == MOVE_POP2);
      w_pop_n       = (w_move == MOVE_POP2) ? 2'd2 : 2'd1;
      w_short       = w_is_pop && (r_occupancy < OCC_W'(w_pop_n));
      // The slot an in-flight fill will occupy is already taken.
      w_push_stall  = w_is_push &&
                      (({1'b0, r_occupancy} + {{OCC_W{1'b0}}, (r_state == FILL)})
                       >= (OCC_W+1)'(DEPTH));
      w_pop_stall   = w_short && ((r_spilled != '0) || (r_state == SPILL));
      w_stall       = w_push_stall || w_pop_stall;
      w_commit      = bus.move_valid && !w_stall;
      w_spill_issue = (r_state == IDLE) && (r_occupancy > OCC_W'(HIGH_WATER));
      w_fill_issue  = (r_state == IDLE) && !w_spill_issue &&
                      (r_occupancy < OCC_W'(LOW_WATER)) && (r_spilled != '0);
      w_fill_ack    = (r_state == FILL) && bus.mem_ack;
      // Core movement, bottom removal and bottom insertion resolve as one sum.
      w_sum         = int'(r_occupancy)
                      + (w_commit ? int'(movement_delta(w_move)) : 0)
                      - int'(w_spill_issue) + int'(w_fill_ack);
      w_occ_next    = (w_sum < 0) ? '0 : OCC_W'(w_sum);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_occupancy <= '0;
         r_spilled   <= '0;
         r_mem_addr  <= WORD_WIDTH'(SPILL_BASE);
         r_mem_wdata <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_occupancy <= w_occ_next;
         if (w_commit && w_short) r_underflow <= 1'b1;
         case (r_state)
            IDLE: begin
               if (w_spill_issue) begin
                  r_mem_wdata <= bus.bottom_value;
                  r_mem_addr  <= WORD_WIDTH'(SPILL_BASE) + r_spilled;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b1;
                  r_state     <= SPILL;
               end else if (w_fill_issue) begin
                  r_mem_addr  <= WORD_WIDTH'(SPILL_BASE) + r_spilled - WORD_WIDTH'(1);
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b0;
                  r_state     <= FILL;
               end
            end
            SPILL: begin
               if (bus.mem_ack) begin
                  r_spilled <= r_spilled + WORD_WIDTH'(1);
                  r_mem_req <= 1'b0;
                  r_state   <= IDLE;
               end
            end
            FILL: begin
               if (bus.mem_ack) begin
                  r_spilled <= r_spilled - WORD_WIDTH'(1);
                  r_mem_req <= 1'b0;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.stall             = w_stall;
   assign bus.bottom_pop        = w_spill_issue;
   assign bus.bottom_push       = w_fill_ack;
   assign bus.bottom_push_value = w_fill_ack ? bus.mem_rdata : '0;
   assign bus.occupancy         = r_occupancy;
   assign bus.spilled           = r_spilled;
   assign bus.underflow         = r_underflow;
   assign bus.mem_req           = r_mem_req;
   assign bus.mem_we            = r_mem_we;
   assign bus.mem_addr          = r_mem_addr;
   assign bus.mem_wdata         = r_mem_wdata;
   assign bus.dbg_state         = r_state;

`ifdef DSTACK_SPILL_STATS_EN
   logic [WORD_WIDTH-1:0] r_spill_count;
   logic [WORD_WIDTH-1:0] r_fill_count;
   logic [WORD_WIDTH-1:0] r_stall_cycles;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_spill_count  <= '0;
         r_fill_count   <= '0;
         r_stall_cycles <= '0;
      end else begin
         if ((r_state == SPILL) && bus.mem_ack && (r_spill_count != '1))
            r_spill_count <= r_spill_count + WORD_WIDTH'(1);
         if (w_fill_ack && (r_fill_count != '1))
            r_fill_count <= r_fill_count + WORD_WIDTH'(1);
         if (bus.move_valid && w_stall)
            r_stall_cycles <= r_stall_cycles + WORD_WIDTH'(1);
      end
   end

   assign bus.spill_count  = r_spill_count;
   assign bus.fill_count   = r_fill_count;
   assign bus.stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_dstack_spill_control.sv
// Directed bench for dstack_spill_control: spill, stall at full depth,
// reset mid-request, fill with pop stall, and sticky underflow.
module tb_dstack_spill_control;
   import dstack_pkg::*;

   localparam logic [31:0] BV = 32'hB077_0000;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_errors;

   dstack_spill_control_if #(.WORD_WIDTH(32), .DEPTH(32)) bus ();

   dstack_spill_control #(
      .WORD_WIDTH(32), .DEPTH(32), .HIGH_WATER(28), .LOW_WATER(4), .SPILL_BASE(0)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input move_e mv, input logic valid);
      bus.movement   = mv;
      bus.move_valid = valid;
   endtask

   task automatic ack_pulse(input logic [31:0] rdata);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = rdata;
      tick();
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset_n           = 1'b0;
      bus.movement      = MOVE_NONE;
      bus.move_valid    = 1'b0;
      bus.bottom_value  = BV;
      bus.mem_ack       = 1'b0;
      bus.mem_rdata     = '0;
      repeat (2) @(posedge clk);
      #1;

      check("rst_occ", bus.occupancy, 0);
      check("rst_spilled", bus.spilled, 0);
      check("rst_underflow", bus.underflow, 0);
      check("rst_mem_req", bus.mem_req, 0);
      check("rst_mem_we", bus.mem_we, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      check("rst_bottom_pop", bus.bottom_pop, 0);
      check("rst_bottom_push", bus.bottom_push, 0);
      check("rst_push_value", bus.bottom_push_value, 0);
      check("rst_stall", bus.stall, 0);
      check("rst_state", bus.dbg_state, IDLE);
      reset_n = 1'b1;

      // 29 pushes cross HIGH_WATER and trigger one spill
      drive(MOVE_PUSH, 1'b1);
      repeat (29) tick();
      drive(MOVE_NONE, 1'b0);
      #1;
      check("s1_occ29", bus.occupancy, 29);
      check("s1_bottom_pop", bus.bottom_pop, 1);
      check("s1_req_before", bus.mem_req, 0);
      tick();
      check("s1_occ28", bus.occupancy, 28);
      check("s1_pop_done", bus.bottom_pop, 0);
      check("s1_req", bus.mem_req, 1);
      check("s1_we", bus.mem_we, 1);
      check("s1_addr", bus.mem_addr, 0);
      check("s1_wdata", bus.mem_wdata, BV);
      check("s1_state", bus.dbg_state, SPILL);
      tick();
      tick();
      check("s1_req_held", bus.mem_req, 1);
      check("s1_addr_held", bus.mem_addr, 0);
      ack_pulse('0);
      #1;
      check("s1_spilled", bus.spilled, 1);
      check("s1_req_drop", bus.mem_req, 0);
      check("s1_occ_after", bus.occupancy, 28);
      check("s1_idle", bus.dbg_state, IDLE);

      // fill the stack to DEPTH while the second spill waits for its ack
      drive(MOVE_PUSH, 1'b1);
      repeat (5) tick();
      check("s2_occ32", bus.occupancy, 32);
      check("s2_stall", bus.stall, 1);
      check("s2_req", bus.mem_req, 1);
      check("s2_addr", bus.mem_addr, 1);
      tick();
      check("s2_occ_hold", bus.occupancy, 32);
      ack_pulse('0);
      check("s2_spilled", bus.spilled, 2);
      check("s2_occ_still32", bus.occupancy, 32);
      check("s2_req_drop", bus.mem_req, 0);
      check("s2_bottom_pop", bus.bottom_pop, 1);
      check("s2_stall_idle", bus.stall, 1);
      drive(MOVE_NONE, 1'b0);
      tick();
      check("s2_occ31", bus.occupancy, 31);
      check("s2_req2", bus.mem_req, 1);
      check("s2_addr2", bus.mem_addr, 2);

      // asynchronous reset in the middle of an outstanding spill
      #2;
      reset_n = 1'b0;
      #1;
      check("s6_occ", bus.occupancy, 0);
      check("s6_spilled", bus.spilled, 0);
      check("s6_req", bus.mem_req, 0);
      check("s6_we", bus.mem_we, 0);
      check("s6_addr", bus.mem_addr, 0);
      check("s6_wdata", bus.mem_wdata, 0);
      check("s6_state", bus.dbg_state, IDLE);
      reset_n = 1'b1;
      ack_pulse('0);
      check("s6_late_ack_spilled", bus.spilled, 0);
      check("s6_late_ack_req", bus.mem_req, 0);

      // build spilled=2, occupancy=4
      drive(MOVE_PUSH, 1'b1);
      repeat (29) tick();
      drive(MOVE_NONE, 1'b0);
      tick();
      ack_pulse('0);
      drive(MOVE_PUSH, 1'b1);
      tick();
      drive(MOVE_NONE, 1'b0);
      tick();
      ack_pulse('0);
      drive(MOVE_POP2, 1'b1);
      repeat (12) tick();
      drive(MOVE_NONE, 1'b0);
      #1;
      check("s3_occ4", bus.occupancy, 4);
      check("s3_spilled2", bus.spilled, 2);
      check("s3_no_req", bus.mem_req, 0);

      // pop below LOW_WATER starts a fill from the top spilled word
      drive(MOVE_POP1, 1'b1);
      tick();
      drive(MOVE_NONE, 1'b0);
      #1;
      check("s3_occ3", bus.occupancy, 3);
      tick();
      check("s3_req", bus.mem_req, 1);
      check("s3_we", bus.mem_we, 0);
      check("s3_addr", bus.mem_addr, 1);
      check("s3_state", bus.dbg_state, FILL);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hDEAD_BEEF;
      #1;
      check("s3_bottom_push", bus.bottom_push, 1);
      check("s3_push_value", bus.bottom_push_value, 32'hDEAD_BEEF);
      tick();
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      #1;
      check("s3_push_done", bus.bottom_push, 0);
      check("s3_push_value0", bus.bottom_push_value, 0);
      check("s3_occ_after", bus.occupancy, 4);
      check("s3_spilled1", bus.spilled, 1);
      check("s3_req_drop", bus.mem_req, 0);

      // pop2 with one entry on chip waits for the pending fill
      drive(MOVE_POP2, 1'b1);
      tick();
      drive(MOVE_POP1, 1'b1);
      tick();
      drive(MOVE_POP2, 1'b1);
      #1;
      check("s4_stall", bus.stall, 1);
      check("s4_fill_addr", bus.mem_addr, 0);
      check("s4_state", bus.dbg_state, FILL);
      tick();
      check("s4_occ_hold", bus.occupancy, 1);
      check("s4_stall_hold", bus.stall, 1);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hCAFE_0001;
      #1;
      check("s4_stall_at_ack", bus.stall, 1);
      check("s4_bottom_push", bus.bottom_push, 1);
      tick();
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      #1;
      check("s4_occ2", bus.occupancy, 2);
      check("s4_spilled0", bus.spilled, 0);
      check("s4_stall_clear", bus.stall, 0);
      tick();
      drive(MOVE_NONE, 1'b0);
      #1;
      check("s4_occ0", bus.occupancy, 0);
      check("s4_no_underflow", bus.underflow, 0);
      tick();
      check("s4_no_fill", bus.mem_req, 0);

      // pop on a totally empty stack: no stall, sticky underflow
      drive(MOVE_POP1, 1'b1);
      #1;
      check("s5_stall", bus.stall, 0);
      tick();
      drive(MOVE_NONE, 1'b0);
      #1;
      check("s5_underflow", bus.underflow, 1);
      check("s5_occ0", bus.occupancy, 0);
      drive(MOVE_PUSH, 1'b1);
      tick();
      drive(MOVE_NONE, 1'b0);
      #1;
      check("s5_occ1", bus.occupancy, 1);
      check("s5_underflow_sticky", bus.underflow, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/dstack_spill_control.md
Name: dstack_spill_control

Overview:
- Sequential controller that keeps the on-chip data stack within its physical depth.
- Tracks on-chip occupancy from the per-cycle stack movement code.
- Spills the bottom-most entry to memory when occupancy is high, and fills it back when occupancy is low.
- Stalls the core when a requested movement cannot be honoured this cycle.
- Sits beside the data-stack control logic; consumes its movement/halt outputs and drives the stack's bottom-end insert/remove strobes plus a single-port memory request channel.

Parameters:
WORD_WIDTH, 32, data and memory address width
DEPTH, 32, physical on-chip stack entries (power of two, ≥8)
HIGH_WATER, 28, spill while occupancy > HIGH_WATER (must be ≤ DEPTH-2)
LOW_WATER, 4, fill while occupancy < LOW_WATER (must be ≥ 2 and < HIGH_WATER)
SPILL_BASE, 0, memory word address of the first spilled entry

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
movement  in  2  00 none, 01 push 1, 10 pop 1, 11 pop 2
move_valid  in  1  movement applies this cycle (core not halted)
stall  out  1  combinational; movement must not commit, and the core holds its instruction
bottom_value  in  WORD_WIDTH  current bottom-most on-chip entry
bottom_pop  out  1  remove the bottom entry this cycle
bottom_push  out  1  insert bottom_push_value below the bottom entry this cycle
bottom_push_value  out  WORD_WIDTH  fill data
occupancy  out  $clog2(DEPTH)+1  on-chip entry count
spilled  out  WORD_WIDTH  number of entries held in memory
underflow  out  1  sticky: pop requested with the stack totally empty
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = spill write, 0 = fill read
mem_addr  out  WORD_WIDTH  word address
mem_wdata  out  WORD_WIDTH  spill data
mem_ack  in  1  one-cycle completion; mem_rdata valid with it on reads
mem_rdata  in  WORD_WIDTH  fill data

Behaviour:
- Reset values:
  - occupancy=0, spilled=0, underflow=0.
  - mem_req=0, mem_we=0, mem_addr=SPILL_BASE, mem_wdata=0.
  - bottom_pop=0, bottom_push=0, bottom_push_value=0.
  - FSM enters IDLE.
  - Reset mid-transaction abandons the request; a late mem_ack is ignored.
- Movement deltas: push +1, pop1 -1, pop2 -2. Movement commits only when move_valid && !stall.
- FSM states:
  - IDLE:
    - If occupancy > HIGH_WATER: latch bottom_value into mem_wdata, mem_addr=SPILL_BASE+spilled, pulse bottom_pop for one cycle, occupancy decremented that cycle. Next: SPILL.
    - Else if occupancy < LOW_WATER and spilled>0: mem_addr=SPILL_BASE+spilled-1. Next: FILL.
    - Spill has priority over fill.
    - mem_req is registered and asserted from the first SPILL/FILL cycle.
  - SPILL: hold mem_req, mem_we=1. On mem_ack: spilled+1, mem_req drops, go to IDLE.
  - FILL: hold mem_req, mem_we=0. On mem_ack: bottom_push=1, bottom_push_value=mem_rdata for one cycle, occupancy+1, spilled-1, go to IDLE.
- Handshake: request fields are stable while mem_req=1; at most one outstanding request; a new request issues no earlier than the cycle after mem_ack.
- Stall (combinational, from current registers):
  - Push stalls when occupancy + (state==FILL) ≥ DEPTH; the slot is reserved for the fill.
  - Pop n stalls when occupancy < n and (spilled>0 or state==SPILL); the core waits for a fill.
  - Pop n with occupancy < n, spilled==0 and state IDLE: no stall, underflow set, occupancy saturates at 0.
- Simultaneous events in one cycle:
  - next occupancy = occupancy + movement delta − bottom_pop + bottom_push, computed as one sum.
  - Core push during a spill-issue cycle is legal.
  - Core pop during a fill-ack cycle is legal when it is not stalled.
- Arithmetic: spilled wraps modulo 2^WORD_WIDTH; no overflow detection.

Optional Feature:
- DSTACK_SPILL_STATS_EN defined:
  - Adds outputs spill_count and fill_count, each WORD_WIDTH wide.
  - Each counter increments on its respective mem_ack, saturates at all-ones, and resets to 0.
  - Adds output stall_cycles: counts cycles with move_valid && stall.
- DSTACK_SPILL_STATS_EN undefined: these ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package dstack_pkg holds:
  - enum for movement codes (MOVE_NONE, MOVE_PUSH, MOVE_POP1, MOVE_POP2).
  - enum for FSM state (IDLE, SPILL, FILL).
  - function movement_delta returning a signed occupancy delta.
- Single module; no sub-module is natural. The occupancy/spilled arithmetic stays inline.

Test Plan:
- Reset, then 29 committed pushes (occupancy 29 > 28) → bottom_pop pulses once, occupancy 28, mem_req mem_we=1 mem_addr=0. Ack after 3 cycles → spilled=1.
- Reach occupancy 32 with mem_ack held low, then push → stall=1, occupancy stays 32 until spill issue drops it to 31.
- spilled=2, occupancy 4, then pop1 → occupancy 3. Fill read at addr 1; mem_ack with mem_rdata=0xDEADBEEF → bottom_push_value=0xDEADBEEF, occupancy 4, spilled 1.
- occupancy 1, fill pending, pop2 → stall until ack; then pop2 commits, occupancy 0.
- Empty stack, spilled=0, pop1 → stall=0, underflow=1 and sticky, occupancy 0.
- Assert reset_n=0 while in SPILL with mem_req=1 → all outputs at reset values immediately; a following mem_ack leaves spilled=0.
